// File: rtl/q_stream_checker_if.sv
// Bus between the Q2 counter stage and its stream checker: sampled value,
// qualifiers, and the checker's status/debug readout.
interface q_stream_checker_if #(
  parameter int N     = 8,
  parameter int ERR_W = 16
);
  logic [N-1:0]     q;
  logic             en;
  logic             clr;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] smp_cnt;
  logic [N-1:0]     first_exp;
  logic [N-1:0]     first_act;

  modport master (
    output q, en, clr,
    input  locked, err, err_cnt, smp_cnt, first_exp, first_act
  );

  modport slave (
    input  q, en, clr,
    output locked, err, err_cnt, smp_cnt, first_exp, first_act
  );
endinterface

// File: rtl/q_stream_checker.sv
// Checks that q advances by STEP (mod 2^N) between enabled samples, locks onto
// the sequence, counts violations while locked and captures the first one.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HUNT   | seeding / counting consecutive good steps toward lock
// ST_LOCKED | tracking; mismatches are errors, MISS_MAX in a row drop lock
module q_stream_checker #(
  parameter int N        = 8,
  parameter int STEP     = 1,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3,
  parameter int ERR_W    = 16
) (
  input logic             clk,
  input logic             rst,
  q_stream_checker_if.slave bus
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
  localparam logic [ERR_W-1:0]  CNT_MAX   = '1;
  localparam logic [N-1:0]      STEP_N    = N'(STEP);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

  state_t            state, state_d;
  logic [N-1:0]      prev;
  logic              have_prev;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;
  logic              cap_done;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;
  logic [ERR_W-1:0]  smp_cnt;
  logic [N-1:0]      first_exp;
  logic [N-1:0]      first_act;

  logic [N-1:0] exp_val;
  logic         step_ok;
  logic         lock_hit;
  logic         miss_hit;
  logic         drop_hit;

  assign exp_val  = prev + STEP_N;
  assign step_ok  = have_prev && (bus.q == exp_val);
  assign lock_hit = bus.en && (state == ST_HUNT) && step_ok && (run == RUN_LAST);
  assign miss_hit = bus.en && (state == ST_LOCKED) && !step_ok;
  assign drop_hit = miss_hit && (miss == MISS_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (lock_hit) state_d = ST_LOCKED;
    if (drop_hit) state_d = ST_HUNT;
  end

  always_comb begin
    bus.locked = (state == ST_LOCKED);
  end

  // Sequence tracking; a miss while locked re-seeds prev so one glitch costs one error.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= '0;
      have_prev <= 1'b0;
      run       <= '0;
      miss      <= '0;
      smp_cnt   <= '0;
    end else if (bus.en) begin
      prev      <= bus.q;
      have_prev <= 1'b1;
      if (smp_cnt != CNT_MAX) smp_cnt <= smp_cnt + ERR_W'(1);
      if (state == ST_HUNT) begin
        run <= step_ok ? run + RUN_W'(1) : '0;
        if (lock_hit) miss <= '0;
      end else if (step_ok) begin
        miss <= '0;
      end else if (drop_hit) begin
        miss <= '0;
        run  <= '0;
      end else begin
        miss <= miss + MISS_W'(1);
      end
    end
  end

  // A mismatch in the same cycle as clr wins: it restarts the statistics at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_cnt   <= '0;
      cap_done  <= 1'b0;
      first_exp <= '0;
      first_act <= '0;
    end else if (miss_hit) begin
      err <= 1'b1;
      if (bus.clr)                  err_cnt <= ERR_W'(1);
      else if (err_cnt != CNT_MAX)  err_cnt <= err_cnt + ERR_W'(1);
      if (bus.clr || !cap_done) begin
        first_exp <= exp_val;
        first_act <= bus.q;
        cap_done  <= 1'b1;
      end
    end else if (bus.clr) begin
      err       <= 1'b0;
      err_cnt   <= '0;
      cap_done  <= 1'b0;
      first_exp <= '0;
      first_act <= '0;
    end
  end

  assign bus.err       = err;
  assign bus.err_cnt   = err_cnt;
  assign bus.smp_cnt   = smp_cnt;
  assign bus.first_exp = first_exp;
  assign bus.first_act = first_act;

endmodule

// File: doc/q_stream_checker.md
# q_stream_checker

Downstream consumer of the N-bit counter output `q` produced by the Q2 stage. The checker samples `q` on each enabled clock and verifies that it advances by a fixed `STEP` modulo 2^N. It locks onto the sequence, counts step violations, and captures the first bad sample for debug readout. It is the hardware counterpart of the text monitor: the same check in synthesizable form, placed directly on Q2's `q` bus.

## Interface
- `N`, 8, width of the checked bus `q`
- `STEP`, 1, expected increment per enabled sample (mod 2^N)
- `LOCK_CNT`, 4, consecutive correct steps required to lock (≥1)
- `MISS_MAX`, 3, consecutive mismatches while locked that drop lock (≥1)
- `ERR_W`, 16, width of error and sample counters

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `q` in N — value from Q2
- `en` in 1 — sample qualifier; when 0, no internal state changes
- `clr` in 1 — synchronous clear of error statistics only
- `locked` out 1 — checker is tracking the sequence
- `err` out 1 — sticky: at least one mismatch since reset or `clr`
- `err_cnt` out ERR_W — mismatches seen while locked, saturating at all-ones
- `smp_cnt` out ERR_W — enabled samples since reset, saturating
- `first_exp` out N — expected value at the first captured mismatch
- `first_act` out N — actual `q` at the first captured mismatch

## Operation
- Internal registers: `prev` (N bits), `have_prev`, `run` (consecutive good steps), `miss` (consecutive misses), `cap_done`, state ∈ {HUNT, LOCKED}.
- `exp = prev + STEP`, truncated to N bits, so wrap from 2^N−1 to 0 is a correct step.
- Every enabled sample: `prev <= q`, `have_prev <= 1`, `smp_cnt` +1 (saturating).
- HUNT, first sample (`have_prev=0`): seed only, `run <= 0`.
- HUNT, `q==exp`: `run` +1. When `run+1 == LOCK_CNT`, go to LOCKED, `miss <= 0`.
- HUNT, `q!=exp`: `run <= 0`. No error is counted.
- LOCKED, `q==exp`: `miss <= 0`.
- LOCKED, `q!=exp`:
  - `err_cnt` +1 (saturating), `err <= 1`.
  - If `!cap_done`: `first_exp <= exp`, `first_act <= q`, `cap_done <= 1`.
  - `miss` +1. When `miss+1 == MISS_MAX`, go to HUNT with `run <= 0`.
  - `prev <= q` (re-seed), so a single glitch costs exactly one error.
- `clr` zeroes `err`, `err_cnt`, `cap_done`, `first_exp`, and `first_act`. It does not touch state, `prev`, `run`, `miss`, or `smp_cnt`.
- `clr` together with a mismatch in the same cycle: the mismatch wins. Result: `err=1`, `err_cnt=1`, capture taken from that sample.
- `rst` overrides everything. All outputs are 0, state is HUNT, `have_prev=0`, `run=miss=0`.
- `rst` mid-operation: the next enabled sample is treated as a fresh seed.

## Timing
- All outputs are registered and update at the edge that samples `q`. They are visible one cycle after the `q`/`en` setup.
- `locked` rises at the edge sampling the LOCK_CNT-th correct step. It falls at the edge sampling the MISS_MAX-th consecutive miss.
- `en=0` cycles are transparent gaps: steps are judged between consecutive enabled samples only.
- No combinational path from inputs to outputs.

## Test plan
Defaults throughout (N=8, STEP=1, LOCK_CNT=4, MISS_MAX=3).
- Lock: `rst` 1 cycle, then `q`=0,1,2,3,4 with `en=1` → `locked` rises at the edge sampling 4; `err=0`; `smp_cnt=5`.
- Wrap: locked, then `q`=253,254,255,0,1 → no error, `locked` stays 1.
- Single glitch: locked at 10, then `q`=11,20,21,22 → `err_cnt=1`, `err=1`, `first_exp=12`, `first_act=20`, `locked` stays 1.
- Lock loss: locked at 5, then `q`=9,40,77 → `err_cnt=3`, `locked` falls at the edge sampling 77. Then 78,79,80,81 → relock at the edge sampling 81; `first_exp=6`, `first_act=9`.
- Gaps and clear:
  - Locked, hold `en=0` for 5 cycles while `q` changes arbitrarily → all outputs unchanged.
  - Assert `clr` together with a mismatching sample → `err_cnt=1`, capture updated.
  - Assert `clr` alone afterwards → `err=0`, `err_cnt=0`, `first_*`=0.
- Reset mid-run: locked with `err_cnt=2`, assert `rst` → next cycle all outputs 0, state HUNT. Then 7,8,9,10,11 → relock.
